// File: rtl/piso_serializer_stream.sv
// Parallel-in/serial-out streaming shifter with a valid/ready word input and a one-word holding buffer.
// Optional even-parity trailer bit when PISO_STREAM_PARITY_EN is defined.
module piso_serializer_stream #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned SR_W     = FRAME_LEN;
  localparam int unsigned IDX_W    = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             sout_first_q, sout_first_d;
  logic             sout_last_q, sout_last_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;

  logic             accept_c;
  logic             at_last_c;
  logic             transfer_c;
  logic [SR_W-1:0]  load_c;

  // Parity (when present) sits at the tail so it leaves after the last data bit.
  always_comb begin
`ifdef PISO_STREAM_PARITY_EN
    load_c = MSB_FIRST ? {hold_q, ^hold_q} : {^hold_q, hold_q};
`else
    load_c = hold_q;
`endif
  end

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    bit_idx_d    = bit_idx_q;

    accept_c   = in_valid && !hold_full_q;
    at_last_c  = (state_q == SHIFT) && (bit_idx_q == LAST_IDX);
    transfer_c = hold_full_q && ((state_q == IDLE) || (shift_en && at_last_c));

    // accept and transfer are exclusive: accept needs an empty buffer, transfer a full one
    if (accept_c) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    if (transfer_c) begin
      sr_d        = load_c;
      bit_idx_d   = '0;
      hold_full_d = 1'b0;
      state_d     = SHIFT;
    end else if ((state_q == SHIFT) && shift_en) begin
      if (at_last_c) begin
        state_d = IDLE;
      end else begin
        sr_d      = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
        bit_idx_d = bit_idx_q + IDX_W'(1);
      end
    end

    // Outputs are registered copies of what the next state will present.
    sout_valid_d = (state_d == SHIFT);
    sout_d       = sout_valid_d ? (MSB_FIRST ? sr_d[SR_W-1] : sr_d[0]) : IDLE_LEVEL;
    sout_first_d = sout_valid_d && (bit_idx_d == '0);
    sout_last_d  = sout_valid_d && (bit_idx_d == LAST_IDX);
    busy_d       = sout_valid_d || hold_full_d;
    in_ready_d   = !hold_full_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      bit_idx_q    <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      bit_idx_q    <= bit_idx_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      sout_first_q <= sout_first_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign sout_first = sout_first_q;
  assign sout_last  = sout_last_q;
  assign busy       = busy_q;
  assign in_ready   = in_ready_q;

endmodule

// File: tb/tb_piso_serializer_stream.sv
// Directed bench for piso_serializer_stream: MSB-first and LSB-first instances share one stimulus.
// Define PISO_STREAM_PARITY_EN for both RTL and bench to exercise the parity trailer.
module tb_piso_serializer_stream;

  localparam int W = 8;
`ifdef PISO_STREAM_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         shift_en;

  logic in_ready_m, sout_m, sout_valid_m, sout_first_m, sout_last_m, busy_m;
  logic in_ready_l, sout_l, sout_valid_l, sout_first_l, sout_last_l, busy_l;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer_stream #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .shift_en(shift_en), .sout(sout_m), .sout_valid(sout_valid_m),
    .sout_first(sout_first_m), .sout_last(sout_last_m), .busy(busy_m)
  );

  piso_serializer_stream #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .shift_en(shift_en), .sout(sout_l), .sout_valid(sout_valid_l),
    .sout_first(sout_first_l), .sout_last(sout_last_l), .busy(busy_l)
  );

  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  // {sout_valid, sout, sout_first, sout_last, busy, in_ready} when idle
  task automatic check_idle(input string name);
    logic [5:0] got_m, got_l;
    got_m = {sout_valid_m, sout_m, sout_first_m, sout_last_m, busy_m, in_ready_m};
    got_l = {sout_valid_l, sout_l, sout_first_l, sout_last_l, busy_l, in_ready_l};
    checks++;
    if (got_m !== 6'b000001) begin
      errors++;
      $display("FAIL %s msb idle: got=%b exp=000001", name, got_m);
    end
    checks++;
    if (got_l !== 6'b000001) begin
      errors++;
      $display("FAIL %s lsb idle: got=%b exp=000001", name, got_l);
    end
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 50; k++) begin
      if (!busy_m && !busy_l) break;
      @(negedge clk);
    end
    checks++;
    if (busy_m || busy_l) begin
      errors++;
      $display("FAIL wait_idle: busy_m=%b busy_l=%b exp=0 after 50 cycles", busy_m, busy_l);
    end
  endtask

  // Called at the negedge where bit 0 of word w is first visible.
  task automatic check_frame(input logic [W-1:0] w, input bit alt, input bit stream_next);
    logic [3:0] got, exp;
    for (int i = 0; i < FL; i++) begin
      for (int r = 0; r < (alt ? 2 : 1); r++) begin
        exp = {1'b1, exp_bit(w, i, 1'b1), (i == 0), (i == FL - 1)};
        got = {sout_valid_m, sout_m, sout_first_m, sout_last_m};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL frame_msb w=%h bit=%0d rep=%0d got=%b exp=%b", w, i, r, got, exp);
        end
        exp = {1'b1, exp_bit(w, i, 1'b0), (i == 0), (i == FL - 1)};
        got = {sout_valid_l, sout_l, sout_first_l, sout_last_l};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL frame_lsb w=%h bit=%0d rep=%0d got=%b exp=%b", w, i, r, got, exp);
        end
        if (stream_next && i == 1) begin
          checks++;
          if ({in_ready_m, busy_m, in_ready_l, busy_l} !== 4'b0101) begin
            errors++;
            $display("FAIL stream_hold ready/busy got=%b exp=0101",
                     {in_ready_m, busy_m, in_ready_l, busy_l});
          end
        end
        shift_en = alt ? (r == 1) : 1'b1;
        @(negedge clk);
        if (stream_next && i == 0) in_valid = 1'b0;
      end
    end
  endtask

  task automatic send_and_check(input logic [W-1:0] w, input bit alt);
    wait_idle();
    in_data  = w;
    in_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({sout_valid_m, in_ready_m, busy_m, sout_valid_l, in_ready_l, busy_l} !== 6'b001001) begin
      errors++;
      $display("FAIL latency w=%h got=%b exp=001001", w,
               {sout_valid_m, in_ready_m, busy_m, sout_valid_l, in_ready_l, busy_l});
    end
    @(negedge clk);
    check_frame(w, alt, 1'b0);
    check_idle("after_frame");
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    shift_en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_held");
    in_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_msb_first();
    send_and_check(8'hA5, 1'b0);
  endtask

  task automatic test_lsb_first();
    send_and_check(8'h3C, 1'b0);
  endtask

  task automatic test_bit_order();
    send_and_check(8'h01, 1'b0);
    send_and_check(8'hC2, 1'b0);
  endtask

  task automatic test_back_to_back();
    wait_idle();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    in_data = 8'h3C;
    @(negedge clk);
    check_frame(8'hA5, 1'b0, 1'b1);
    check_frame(8'h3C, 1'b0, 1'b0);
    check_idle("back_to_back_end");
  endtask

  task automatic test_shift_en();
    send_and_check(8'hA5, 1'b1);
  endtask

  task automatic test_mid_frame_reset();
    wait_idle();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    shift_en = 1'b1;
    @(negedge clk);
    in_data = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({sout_valid_m, in_ready_m, busy_m, sout_m} !== 4'b1011) begin
      errors++;
      $display("FAIL mid_frame_setup got=%b exp=1011", {sout_valid_m, in_ready_m, busy_m, sout_m});
    end
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if ({sout_valid_m, busy_m, sout_valid_l, busy_l} !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset cycle=%0d got=%b exp=0000", k,
                 {sout_valid_m, busy_m, sout_valid_l, busy_l});
      end
    end
  endtask

`ifdef PISO_STREAM_PARITY_EN
  task automatic test_parity();
    send_and_check(8'hA5, 1'b0);
    send_and_check(8'h07, 1'b0);
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    shift_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_bit_order();
    test_back_to_back();
    test_shift_en();
    test_mid_frame_reset();
`ifdef PISO_STREAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
